serial_negate_ctrl: RTL and testbench

Word-level sequencer for the bit-serial two's complement negator. Accepts a parallel WIDTH-bit word over a valid/ready handshake and streams it LSB-first through an internal serial complement cell: bits pass unchanged up to and including the first 1, and every later bit is inverted. It reassembles the result and presents it with an overflow flag on a valid/ready output. It sits between a parallel producer and consumer, owns the complement cell's state, and clears that state at the start of every word.

---
 rtl/serial_negate_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_negate_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_negate_ctrl.sv
// serial_negate_ctrl: word-level sequencer around a bit-serial two's complement cell.
// A word is accepted in IDLE, then streamed LSB-first through the complement cell
// in SHIFT, one bit per cycle. The reassembled result is then presented in HOLD
// until the consumer takes it.
module serial_negate_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             t_clock,
    input  logic             r,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy,
    output logic             ser_x,
    output logic             ser_y
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   count_q;
    logic               seen_q;
    logic               ovf_q;

    logic               cell_x;
    logic               cell_y;
    logic               accept;
    logic               last_bit;

    // Serial complement cell: pass bits through up to the first 1, invert afterwards.
    assign cell_x = shift_q[0];
    assign cell_y = cell_x ^ seen_q;

    // The presented result and flag hold across IDLE until the next word completes.
    assign out_data = data_q;
    assign out_ovf  = ovf_q;

    // State register.
    always_ff @(posedge t_clock or posedge r) begin
        if (r) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs; outputs depend on registers only.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_bit  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        ser_x     = 1'b0;
        ser_y     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                ser_x = cell_x;
                ser_y = cell_y;
                if (count_q == LAST_BIT) begin
                    last_bit = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial datapath: load on acceptance, one bit per SHIFT cycle, capture on the last bit.
    always_ff @(posedge t_clock or posedge r) begin
        if (r) begin
            shift_q  <= '0;
            result_q <= '0;
            data_q   <= '0;
            count_q  <= '0;
            seen_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            shift_q  <= in_data;
            result_q <= '0;
            count_q  <= '0;
            seen_q   <= 1'b0;
        end else if (state_q == SHIFT) begin
            result_q <= {cell_y, result_q[WIDTH-1:1]};
            shift_q  <= {1'b0, shift_q[WIDTH-1:1]};
            seen_q   <= seen_q | cell_x;
            if (last_bit) begin
                // Only the most negative value reaches its MSB without having seen a 1.
                ovf_q  <= cell_x & ~seen_q;
                data_q <= {cell_y, result_q[WIDTH-1:1]};
            end else begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed bench for serial_negate_ctrl at WIDTH=8.
module tb_serial_negate_ctrl;

    logic       t_clock;
    logic       r;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       busy;
    logic       ser_x;
    logic       ser_y;

    int vectors;
    int miscompares;
    int cyc;

    serial_negate_ctrl #(.WIDTH(8)) dut (
        .t_clock   (t_clock),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .ser_x     (ser_x),
        .ser_y     (ser_y)
    );

    // 10-unit clock period.
    initial t_clock = 1'b0;
    always #5 t_clock = ~t_clock;

    // Cycle counter advanced on the sampling edge.
    initial cyc = 0;
    always @(negedge t_clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one word at a negedge in IDLE, check the serial stream and the result.
    // Leaves the bench at the negedge after the HOLD edge (DUT back in IDLE).
    task automatic run_word(input logic [7:0] d, input logic [7:0] e, input logic eo, input string tag);
        in_data  = d;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge t_clock);
        @(negedge t_clock);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.ser_x[%0d]", tag, i), 32'(ser_x), 32'(d[i]));
            chk($sformatf("%s.ser_y[%0d]", tag, i), 32'(ser_y), 32'(e[i]));
            chk($sformatf("%s.early_valid[%0d]", tag, i), 32'(out_valid), 32'd0);
            @(negedge t_clock);
        end
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out_data"}, 32'(out_data), 32'(e));
        chk({tag, ".out_ovf"}, 32'(out_ovf), 32'(eo));
        chk({tag, ".ser_y_hold"}, 32'(ser_y), 32'd0);
        @(negedge t_clock);
        chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".held_data"}, 32'(out_data), 32'(e));
        chk({tag, ".held_ovf"}, 32'(out_ovf), 32'(eo));
    endtask

    initial begin
        logic [7:0] words [12];
        int n;
        int acc_cyc;
        int prev_cyc;
        int pulses;

        vectors     = 0;
        miscompares = 0;
        r           = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b1;

        // Reset state.
        repeat (2) @(negedge t_clock);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.out_ovf", 32'(out_ovf), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ser_x", 32'(ser_x), 32'd0);
        chk("rst.ser_y", 32'(ser_y), 32'd0);
        r = 1'b0;
        @(negedge t_clock);

        // Basic vectors and arithmetic boundaries.
        run_word(8'h01, 8'hFF, 1'b0, "w01");
        run_word(8'h5A, 8'hA6, 1'b0, "w5A");
        run_word(8'h80, 8'h80, 1'b1, "w80");
        run_word(8'h00, 8'h00, 1'b0, "w00");
        run_word(8'h7F, 8'h81, 1'b0, "w7F");

        // Backpressure with a second word pending throughout.
        in_data  = 8'h03;
        in_valid = 1'b1;
        @(posedge t_clock);
        @(negedge t_clock);
        in_data   = 8'h07;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge t_clock);
            n++;
        end
        chk("bp.out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp.out_data[%0d]", i), 32'(out_data), 32'hFD);
            chk($sformatf("bp.out_ovf[%0d]", i), 32'(out_ovf), 32'd0);
            chk($sformatf("bp.in_ready[%0d]", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp.busy[%0d]", i), 32'(busy), 32'd1);
            chk($sformatf("bp.valid[%0d]", i), 32'(out_valid), 32'd1);
            @(negedge t_clock);
        end
        out_ready = 1'b1;
        @(negedge t_clock);
        chk("bp.idle", 32'(in_ready), 32'd1);
        @(negedge t_clock);
        chk("bp.accepted", 32'(busy), 32'd1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge t_clock);
            n++;
        end
        chk("bp2.out_valid", 32'(out_valid), 32'd1);
        chk("bp2.out_data", 32'(out_data), 32'hF9);
        chk("bp2.out_ovf", 32'(out_ovf), 32'd0);
        @(negedge t_clock);

        // Reset asserted mid-SHIFT.
        in_data  = 8'h10;
        in_valid = 1'b1;
        @(posedge t_clock);
        @(negedge t_clock);
        in_valid = 1'b0;
        repeat (3) @(negedge t_clock);
        chk("mid.busy_before", 32'(busy), 32'd1);
        #1;
        r = 1'b1;
        #1;
        chk("mid.in_ready", 32'(in_ready), 32'd1);
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.out_data", 32'(out_data), 32'd0);
        chk("mid.out_ovf", 32'(out_ovf), 32'd0);
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.ser_x", 32'(ser_x), 32'd0);
        chk("mid.ser_y", 32'(ser_y), 32'd0);
        repeat (2) @(negedge t_clock);
        r = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge t_clock);
            if (out_valid || busy) pulses++;
        end
        chk("mid.no_pulse", 32'(pulses), 32'd0);
        run_word(8'h10, 8'hF0, 1'b0, "w10");

        // Streaming with out_ready high and in_valid held.
        for (int k = 0; k < 12; k++) words[k] = 8'($urandom_range(0, 255));
        words[3] = 8'h80;
        in_data  = words[0];
        in_valid = 1'b1;
        prev_cyc = 0;
        for (int k = 0; k < 12; k++) begin
            n = 0;
            while (!in_ready && n < 30) begin
                @(negedge t_clock);
                n++;
            end
            chk($sformatf("st%0d.ready", k), 32'(in_ready), 32'd1);
            @(posedge t_clock);
            acc_cyc = cyc;
            if (k > 0) chk($sformatf("st%0d.interval", k), 32'(acc_cyc - prev_cyc), 32'd10);
            prev_cyc = acc_cyc;
            @(negedge t_clock);
            if (k < 11) in_data = words[k+1];
            else in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge t_clock);
                n++;
            end
            chk($sformatf("st%0d.valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("st%0d.data", k), 32'(out_data), 32'(8'(-words[k])));
            chk($sformatf("st%0d.ovf", k), 32'(out_ovf), 32'(words[k] == 8'h80));
            @(negedge t_clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
